// File: rtl/bool_postulate_checker.sv
// rtl/bool_postulate_checker.sv - exhaustive 8-vector self-check of the boolean-postulate block
module bool_postulate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [26:0] i_dut_out,
    output logic        o_x,
    output logic        o_y,
    output logic        o_z,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [18:0] o_fail_mask,
    output logic        o_fail_valid,
    output logic [2:0]  o_fail_vec,
    output logic [3:0]  o_err_count
);

    // Sweep sequencer states: one DRIVE, SETTLE_CYCLES waits and one CHECK per vector.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic [18:0]      r_mask;
    logic             r_fail_valid;
    logic [2:0]       r_fail_vec;
    logic [3:0]       r_err_count;
    logic             r_pass;

    // Returned outputs re-indexed so w_o[k] is o{k} of the postulate block.
    logic [27:1]      w_o;
    logic             w_x;
    logic             w_y;
    logic             w_z;
    logic [18:0]      w_fail;
    logic [18:0]      w_mask_next;
    logic             w_any_fail;

    assign w_o = i_dut_out;
    assign w_x = r_vec[2];
    assign w_y = r_vec[1];
    assign w_z = r_vec[0];

    // Identity checks for the vector currently applied; a set bit marks a broken law.
    always_comb begin
        w_fail     = '0;
        // Identity elements and null elements.
        w_fail[0]  = (w_o[1]  != w_x);
        w_fail[1]  = (w_o[2]  != 1'b0);
        w_fail[2]  = (w_o[3]  != 1'b1);
        w_fail[3]  = (w_o[4]  != w_x);
        // Complement, idempotence and involution.
        w_fail[4]  = (w_o[5]  != 1'b1);
        w_fail[5]  = (w_o[6]  != 1'b0);
        w_fail[6]  = (w_o[7]  != w_x);
        w_fail[7]  = (w_o[8]  != w_x);
        w_fail[8]  = (w_o[9]  != w_x);
        // Commutative and associative pairs: both sides must agree.
        w_fail[9]  = (w_o[10] != w_o[11]);
        w_fail[10] = (w_o[12] != w_o[13]);
        w_fail[11] = (w_o[14] != w_o[15]);
        w_fail[12] = (w_o[16] != w_o[17]);
        // Absorption collapses back to x.
        w_fail[13] = (w_o[18] != w_x);
        w_fail[14] = (w_o[19] != w_x);
        // Distributive and De Morgan pairs.
        w_fail[15] = (w_o[20] != w_o[21]);
        w_fail[16] = (w_o[22] != w_o[23]);
        w_fail[17] = (w_o[24] != w_o[25]);
        w_fail[18] = (w_o[26] != w_o[27]);
    end

    assign w_mask_next = r_mask | w_fail;
    assign w_any_fail  = |w_fail;

    // Sweep sequencer and sticky result registers; reset aborts any sweep in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_vec        <= 3'd0;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 3'd0;
            r_err_count  <= 4'd0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mask       <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= 3'd0;
                        r_err_count  <= 4'd0;
                        r_pass       <= 1'b0;
                        r_vec        <= 3'd0;
                        r_state      <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= CNT_LOAD;
                    if (SETTLE_CYCLES == 0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_CHECK: begin
                    r_mask <= w_mask_next;
                    if (w_any_fail) begin
                        r_err_count <= r_err_count + 4'd1;
                        if (!r_fail_valid) begin
                            r_fail_vec   <= r_vec;
                            r_fail_valid <= 1'b1;
                        end
                    end
                    if (r_vec == 3'd7) begin
                        // Verdict is registered on entry to DONE so it is visible with o_done.
                        r_pass  <= (w_mask_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + 3'd1;
                        r_state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_x          = w_x;
    assign o_y          = w_y;
    assign o_z          = w_z;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_pass       = r_pass;
    assign o_fail_mask  = r_mask;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_vec   = r_fail_vec;
    assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_bool_postulate_checker.sv
// tb/tb_bool_postulate_checker.sv - scoreboard bench for bool_postulate_checker
module tb_bool_postulate_checker;

    localparam int SETTLE = 2;
    localparam int LAT    = 8 * (SETTLE + 2);

    // Law table: kind 0 -> o{a}==0, 1 -> o{a}==1, 2 -> o{a}==x, 3 -> o{a}==o{b}.
    localparam int LAW_KIND [19] = '{2,0,1,2,1,0,2,2,2,3,3,3,3,2,2,3,3,3,3};
    localparam int LAW_A    [19] = '{1,2,3,4,5,6,7,8,9,10,12,14,16,18,19,20,22,24,26};
    localparam int LAW_B    [19] = '{0,0,0,0,0,0,0,0,0,11,13,15,17,0,0,21,23,25,27};

    typedef struct {
        logic [18:0] mask;
        logic [3:0]  err;
        logic [2:0]  fvec;
        logic        fvalid;
        logic        pass;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [26:0] dut_out;
    logic        o_x, o_y, o_z, o_busy, o_done, o_pass, o_fail_valid;
    logic [18:0] o_fail_mask;
    logic [2:0]  o_fail_vec;
    logic [3:0]  o_err_count;

    int   fault_mode = 0;
    int   fault_bit  = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;
    int   mon_d;

    bool_postulate_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dut_out(dut_out),
        .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_fail_mask(o_fail_mask), .o_fail_valid(o_fail_valid),
        .o_fail_vec(o_fail_vec), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [26:0] golden(input logic x, input logic y, input logic z);
        logic [27:1] o;
        o[1]  = x | 1'b0;           o[2]  = x & 1'b0;
        o[3]  = x | 1'b1;           o[4]  = x & 1'b1;
        o[5]  = x | ~x;             o[6]  = x & ~x;
        o[7]  = x | x;              o[8]  = x & x;
        o[9]  = ~(~x);
        o[10] = x | y;              o[11] = y | x;
        o[12] = x & y;              o[13] = y & x;
        o[14] = x | (y | z);        o[15] = (x | y) | z;
        o[16] = x & (y & z);        o[17] = (x & y) & z;
        o[18] = x | (x & y);        o[19] = x & (x | y);
        o[20] = x | (y & z);        o[21] = (x | y) & (x | z);
        o[22] = x & (y | z);        o[23] = (x & y) | (x & z);
        o[24] = ~(x | y);           o[25] = ~x & ~y;
        o[26] = ~(x & y);           o[27] = ~x | ~y;
        return o;
    endfunction

    function automatic logic [26:0] apply_fault(input logic [26:0] v, input int mode, input int b);
        logic [26:0] r;
        r = v;
        case (mode)
            1: r[b] = 1'b0;
            2: r[b] = 1'b1;
            3: r[b] = ~r[b];
            default: r = v;
        endcase
        return r;
    endfunction

    // Postulate block model with optional injected fault.
    always_comb dut_out = apply_fault(golden(o_x, o_y, o_z), fault_mode, fault_bit);

    // Reference sweep over all eight vectors using the law table.
    function automatic exp_t ref_sweep(input int mode, input int b);
        exp_t e;
        e.mask = '0; e.err = '0; e.fvec = '0; e.fvalid = 1'b0; e.start = 0;
        for (int v = 0; v < 8; v++) begin
            logic [26:0] out;
            logic [18:0] f;
            logic x;
            x   = (v >= 4);
            out = apply_fault(golden(x, ((v / 2) % 2) == 1, (v % 2) == 1), mode, b);
            f   = '0;
            for (int n = 0; n < 19; n++) begin
                case (LAW_KIND[n])
                    0: f[n] = out[LAW_A[n]-1] != 1'b0;
                    1: f[n] = out[LAW_A[n]-1] != 1'b1;
                    2: f[n] = out[LAW_A[n]-1] != x;
                    default: f[n] = out[LAW_A[n]-1] != out[LAW_B[n]-1];
                endcase
            end
            e.mask = e.mask | f;
            if (f != 0) begin
                e.err = e.err + 4'd1;
                if (!e.fvalid) begin
                    e.fvec   = 3'(v);
                    e.fvalid = 1'b1;
                end
            end
        end
        e.pass = (e.mask == 0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [18:0] m, input int er, input int fv, input logic val);
        exp_t e;
        e.mask = m; e.err = 4'(er); e.fvec = 3'(fv); e.fvalid = val; e.pass = (m == 0); e.start = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: tracks the in-flight sweep, checks the vector walk and pops on o_done.
    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            mon_e = q[0];
            mon_d = cyc - mon_e.start;
            if (mon_d >= 0 && mon_d <= LAT) begin
                chk("vec_walk", {29'd0, o_x, o_y, o_z}, (mon_d >= LAT) ? 32'd7 : 32'(mon_d / (SETTLE + 2)));
                chk("busy", {31'd0, o_busy}, 32'd1);
            end
            if (o_done || mon_d >= LAT) begin
                chk("done_latency", 32'(mon_d), 32'(LAT));
                chk("done_pulse", {31'd0, o_done}, 32'd1);
                chk("fail_mask", {13'd0, o_fail_mask}, {13'd0, mon_e.mask});
                chk("err_count", {28'd0, o_err_count}, {28'd0, mon_e.err});
                chk("fail_valid", {31'd0, o_fail_valid}, {31'd0, mon_e.fvalid});
                if (mon_e.fvalid) chk("fail_vec", {29'd0, o_fail_vec}, {29'd0, mon_e.fvec});
                chk("pass", {31'd0, o_pass}, {31'd0, mon_e.pass});
                void'(q.pop_front());
            end
        end else if (!rst && o_done) begin
            chk("unexpected_done", {31'd0, o_done}, 32'd0);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * LAT + 20; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) return;
        end
        chk("sweep_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic run_sweep(input exp_t e, input bit repulse);
        exp_t t;
        t = e;
        pulse_start();
        t.start = cyc;
        q.push_back(t);
        if (repulse) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_pass", {31'd0, o_pass}, {31'd0, e.pass});
        chk("hold_mask", {13'd0, o_fail_mask}, {13'd0, e.mask});
        chk("hold_idle", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_xyz"}, {29'd0, o_x, o_y, o_z}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, o_pass}, 32'd0);
        chk({tag, "_mask"}, {13'd0, o_fail_mask}, 32'd0);
        chk({tag, "_fvalid"}, {31'd0, o_fail_valid}, 32'd0);
        chk({tag, "_fvec"}, {29'd0, o_fail_vec}, 32'd0);
        chk({tag, "_errcnt"}, {28'd0, o_err_count}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");

        fault_mode = 0;
        run_sweep(mk(19'h00000, 0, 0, 1'b0), 1'b0);
        fault_mode = 1; fault_bit = 2;
        run_sweep(mk(19'h00004, 8, 0, 1'b1), 1'b0);
        fault_mode = 1; fault_bit = 17;
        run_sweep(mk(19'h02000, 4, 4, 1'b1), 1'b0);
        fault_mode = 3; fault_bit = 10;
        run_sweep(mk(19'h00200, 8, 0, 1'b1), 1'b0);
        fault_mode = 0;
        run_sweep(mk(19'h00000, 0, 0, 1'b0), 1'b1);

        // Abort mid-sweep with reset once vector 3 is on the outputs.
        fault_mode = 1; fault_bit = 2;
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 4 * LAT && !seen; i++) begin
                @(negedge clk);
                if ({o_x, o_y, o_z} == 3'd3) seen = 1'b1;
            end
            chk("reach_vec3", {31'd0, seen}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("abort");
        repeat (LAT + 4) @(negedge clk);
        chk("abort_stays_idle", {31'd0, o_busy}, 32'd0);
        fault_mode = 0;
        run_sweep(mk(19'h00000, 0, 0, 1'b0), 1'b0);

        for (int k = 0; k < 24; k++) begin
            fault_mode = int'($urandom_range(0, 3));
            fault_bit  = int'($urandom_range(0, 26));
            run_sweep(ref_sweep(fault_mode, fault_bit), bit'($urandom_range(0, 1)));
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/bool_postulate_checker.md
Name: bool_postulate_checker

Overview:
Exhaustive self-check stage wrapped around the boolean-postulate block (x, y, z in; 27 law outputs out). It drives all 8 combinations of x/y/z into the block and samples the 27 returned outputs. For each of 19 identities it checks the two sides against each other or against the expected constant/variable, then reports a sticky per-law failure mask, the first failing vector, a failing-vector count and a pass flag. It is used as on-chip BIST for the postulate block and as a bench-free bring-up check.

Parameters:
SETTLE_CYCLES, 2, number of wait cycles after the DRIVE cycle before DUT outputs are sampled (0 allowed).
CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
i_clk  input  1  single clock; all state changes on rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  start-sweep request; sampled only in IDLE
i_dut_out  input  27  DUT outputs; bit k-1 = o_out{k}
o_x  output  1  drives DUT i_x; equals vec[2]
o_y  output  1  drives DUT i_y; equals vec[1]
o_z  output  1  drives DUT i_z; equals vec[0]
o_busy  output  1  high in DRIVE/SETTLE/CHECK/DONE
o_done  output  1  one-cycle pulse, high exactly while in DONE
o_pass  output  1  1 when sticky fail mask is zero at end of sweep; held
o_fail_mask  output  19  sticky per-law failure bits, see law list
o_fail_valid  output  1  at least one vector failed in the current/last sweep
o_fail_vec  output  3  vector {x,y,z} of first failure; valid when o_fail_valid
o_err_count  output  4  number of vectors (0..8) with at least one law failing

Behaviour:
- Reset (i_rst=1 at edge): state IDLE, vec=0, o_x/o_y/o_z=0, o_busy=0, o_done=0, o_pass=0, o_fail_mask=0, o_fail_valid=0, o_fail_vec=0, o_err_count=0. Reset mid-sweep aborts immediately; no partial result is kept.
- FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: i_start=1 -> clear mask, fail_valid, fail_vec, err_count, pass; set vec=0; go DRIVE. Otherwise stay in IDLE and hold the last results.
- DRIVE (1 cycle): o_x/y/z are registered from vec and stable; load the settle counter with SETTLE_CYCLES. Go to SETTLE, or directly to CHECK if SETTLE_CYCLES=0.
- SETTLE: decrement each cycle; go CHECK when the count reaches 1 (exactly SETTLE_CYCLES cycles spent here).
- CHECK (1 cycle): sample i_dut_out and compute 19 fail bits f[18:0]; mask |= f. If f!=0: err_count+1, and if fail_valid=0 then fail_vec=vec and fail_valid=1. If vec=7 go DONE; else vec+1 and go DRIVE.
- DONE (1 cycle): o_done=1, o_pass=(mask==0); go IDLE. Results hold until the next accepted start.
- Latency: o_done is high in the cycle after edge number 8*(SETTLE_CYCLES+2), counting the edge that samples i_start as edge 0. With the default this is 32.
- i_start is ignored outside IDLE. There is no restart mid-sweep.
- Law list, fail bit n = mismatch, using x,y,z = current vec and o{k} = i_dut_out[k-1]:
  - 0: o1!=x; 1: o2!=0; 2: o3!=1; 3: o4!=x
  - 4: o5!=1 (complement law, x+x'=1); 5: o6!=0; 6: o7!=x; 7: o8!=x; 8: o9!=x
  - 9: o10!=o11; 10: o12!=o13; 11: o14!=o15; 12: o16!=o17
  - 13: o18!=x; 14: o19!=x; 15: o20!=o21; 16: o22!=o23; 17: o24!=o25; 18: o26!=o27
- Pair laws 9-12 and 15-18 compare the two sides only; a fault common to both sides is not detected, by design.

Test Plan:
- Correct postulate block connected, SETTLE_CYCLES=2, pulse i_start -> o_done pulses after 32 edges; o_pass=1, o_fail_mask=0, o_err_count=0, o_fail_valid=0; o_x/y/z step through 000..111.
- i_dut_out[2] forced 0 -> o_fail_mask=19'h00004, o_err_count=8, o_fail_vec=000, o_pass=0.
- i_dut_out[17] (o18) stuck 0 -> o_fail_mask bit13 only, o_err_count=4, o_fail_vec=100.
- i_dut_out[10] (o11) inverted -> bit9 set, o_err_count=8, o_fail_vec=000; second i_start with the fault removed -> clean pass, counters cleared.
- i_start re-pulsed at cycle 5 of a sweep -> ignored, o_done still at edge 32; i_rst at vec=3 -> next cycle all outputs at reset values and state IDLE; a new start gives a normal run.
- SETTLE_CYCLES=0 build -> o_done after 16 edges, same results as the first scenario.
